// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial arithmetic blocks: FSM state encoding
// and the default operand width reused by the adder/subtractor top-levels.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a bit counter that can reach width-1 without wrapping.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Single-bit half subtractor: diff = a - b, borrow set when a < b.
// Two of these plus an OR form one full-subtract bit slice.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock, with a start/done handshake.
// Produces the modular difference, the unsigned borrow and signed overflow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CNT_W = count_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t state, next_state;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] result_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic             borrow_q;
  logic             a_msb;
  logic             b_msb;

  logic             hs0_diff;
  logic             hs0_borrow;
  logic             bit_diff;
  logic             hs1_borrow;
  logic             bit_borrow;
  logic             last_bit;
  logic [WIDTH-1:0] result_next;

  // First cell subtracts the operand bits, second subtracts the incoming borrow.
  half_subtractor u_hs0 (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .diff   (hs0_diff),
    .borrow (hs0_borrow)
  );

  half_subtractor u_hs1 (
    .a      (hs0_diff),
    .b      (borrow_q),
    .diff   (bit_diff),
    .borrow (hs1_borrow)
  );

  assign bit_borrow  = hs0_borrow | hs1_borrow;
  assign last_bit    = (bit_cnt == LAST_BIT);
  assign result_next = {bit_diff, result_sr};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Results only move on the final bit edge, so they persist across later starts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      result_sr  <= '0;
      bit_cnt    <= '0;
      borrow_q   <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr     <= a;
            b_sr     <= b;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            borrow_q <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        RUN: begin
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          result_sr <= result_next[WIDTH-1:1];
          borrow_q  <= bit_borrow;
          bit_cnt   <= bit_cnt + CNT_W'(1);
          if (last_bit) begin
            diff       <= result_next;
            borrow_out <= bit_borrow;
            overflow   <= (a_msb != b_msb) && (result_next[WIDTH-1] != a_msb);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised and directed bench for serial_subtractor against an arithmetic
// reference model; checks timing of busy/done as well as the results.
module tb_serial_subtractor;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_diff = '0;
  logic         last_borrow = 1'b0;
  logic         last_ovf = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned difference and signed range test.
  function automatic void refModel(input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] d, output logic br, output logic ov);
    longint sx;
    longint sy;
    longint res;
    sx  = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
    sy  = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
    res = sx - sy;
    d   = W'(longint'(x) - longint'(y));
    br  = longint'(x) < longint'(y);
    ov  = (res > ((longint'(1) << (W - 1)) - 1)) || (res < -(longint'(1) << (W - 1)));
  endfunction

  task automatic applyStimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                               input bit poke_run, input bit poke_done);
    logic [W-1:0] exp_d;
    logic         exp_br;
    logic         exp_ov;
    int           cycles;
    int           busy_cnt;
    refModel(op_a, op_b, exp_d, exp_br, exp_ov);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 4 * W) begin
      if (busy) busy_cnt++;
      if (cycles == 3) begin
        checkOutput("hold_diff", 32'(diff), 32'(last_diff));
        checkOutput("hold_borrow", 32'(borrow_out), 32'(last_borrow));
        checkOutput("hold_ovf", 32'(overflow), 32'(last_ovf));
      end
      start = poke_run && (cycles == 5);
      if (poke_run && cycles == 5) begin
        a = '1;
        b = '0;
      end
      @(negedge clk);
      cycles++;
    end
    checkOutput("done_seen", 32'(done), 32'd1);
    checkOutput("latency", 32'(cycles), 32'(W));
    checkOutput("busy_cycles", 32'(busy_cnt), 32'(W));
    checkOutput("busy_in_done", 32'(busy), 32'd0);
    checkOutput("diff", 32'(diff), 32'(exp_d));
    checkOutput("borrow_out", 32'(borrow_out), 32'(exp_br));
    checkOutput("overflow", 32'(overflow), 32'(exp_ov));
    last_diff   = exp_d;
    last_borrow = exp_br;
    last_ovf    = exp_ov;
    if (poke_done) begin
      start = 1'b1;
      a     = W'($urandom);
      b     = W'($urandom);
      @(negedge clk);
      start = 1'b0;
      checkOutput("done_pulse_width", 32'(done), 32'd0);
      checkOutput("start_in_done_busy", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("start_in_done_ignored", 32'(busy), 32'd0);
      checkOutput("diff_held", 32'(diff), 32'(exp_d));
    end else begin
      @(negedge clk);
      checkOutput("done_pulse_width", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int done_cnt;
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_diff", 32'(diff), 32'd0);
    checkOutput("rst_borrow", 32'(borrow_out), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    done_cnt = 0;
    repeat (20) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    checkOutput("idle_quiet", 32'(done_cnt), 32'd0);

    applyStimulus(16'h0005, 16'h0003, 1'b0, 1'b0);
    applyStimulus(16'h0003, 16'h0005, 1'b0, 1'b0);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'h1234, 16'h0234, 1'b1, 1'b1);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

    // Reset in the middle of an operation discards it.
    a     = 16'h00FF;
    b     = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_diff", 32'(diff), 32'd0);
    checkOutput("midrst_borrow", 32'(borrow_out), 32'd0);
    checkOutput("midrst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    last_diff   = '0;
    last_borrow = 1'b0;
    last_ovf    = 1'b0;
    done_cnt = 0;
    repeat (20) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    checkOutput("midrst_no_done", 32'(done_cnt), 32'd0);
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);

    for (k = 0; k < 30; k++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'b0, 1'b0);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
